// File: rtl/chunked_add_seq_pkg.sv
// Shared definitions for the chunked add/sub sequencer: state encoding, default
// widths, the reduction modulus and the chunk counter width helper.
package chunked_add_seq_pkg;

  localparam int unsigned DATA_W_DEF  = 64;
  localparam int unsigned CHUNK_W_DEF = 16;
  localparam logic [63:0] MOD_P_DEF   = 64'hFFFF_FFFF_0000_0001;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StRun    = 2'd1;
  localparam state_t StReduce = 2'd2;
  localparam state_t StDone   = 2'd3;

  // Never returns zero so a single-chunk build still has a legal counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_chunk_add.sv
// Combinational W-bit carry-lookahead slice built from 3-bit group cells whose
// group generate/propagate terms ripple from one group to the next.
module cla_chunk_add
  import chunked_add_seq_pkg::*;
#(
  parameter int unsigned W = CHUNK_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out
);

  localparam int unsigned NGRP = (W + 2) / 3;
  localparam int unsigned WP   = NGRP * 3;

  always_comb begin
    logic [WP-1:0]  g;
    logic [WP-1:0]  p;
    logic [WP-1:0]  c;
    logic [NGRP:0]  gc;
    // Pad bits propagate without generating, so a partial top group passes its carry through.
    g        = '0;
    p        = '1;
    g[W-1:0] = a & b;
    p[W-1:0] = a ^ b;
    c        = '0;
    gc       = '0;
    gc[0]    = c_in;
    for (int i = 0; i < int'(NGRP); i++) begin
      c[3*i]   = gc[i];
      c[3*i+1] = g[3*i] | (p[3*i] & gc[i]);
      c[3*i+2] = g[3*i+1] | (p[3*i+1] & g[3*i]) | (p[3*i+1] & p[3*i] & gc[i]);
      gc[i+1]  = g[3*i+2] | (p[3*i+2] & g[3*i+1]) | (p[3*i+2] & p[3*i+1] & g[3*i]) |
                 ((&p[3*i +: 3]) & gc[i]);
    end
    sum   = p[W-1:0] ^ c[W-1:0];
    c_out = gc[NGRP];
  end

endmodule

// File: rtl/chunked_add_seq.sv
// Multi-cycle DATA_W add/sub that reuses one CHUNK_W CLA slice, LS chunk first.
// Define CHUNKED_ADD_MOD_SUB_EN to add a second pass reducing the result modulo MOD_P.
module chunked_add_seq
  import chunked_add_seq_pkg::*;
#(
  parameter int unsigned       DATA_W  = DATA_W_DEF,
  parameter int unsigned       CHUNK_W = CHUNK_W_DEF,
  parameter logic [DATA_W-1:0] MOD_P   = DATA_W'(MOD_P_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              sub_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum_out,
  output logic              carry_out
);

  localparam int unsigned NCHUNK = DATA_W / CHUNK_W;
  localparam int unsigned CNT_W  = cnt_width(NCHUNK);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                sub_q, sub_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                cout_q, cout_d;
  logic [DATA_W-1:0]   mod_op;
  logic [CHUNK_W-1:0]  slice_a, slice_b, slice_sum;
  logic                slice_cout;

`ifdef CHUNKED_ADD_MOD_SUB_EN
  logic                c1_q, c1_d;
  logic [DATA_W-1:0]   red;
`endif

  // Second pass adds -P (two's complement of P) in add mode, +P in sub mode.
  assign mod_op = sub_q ? MOD_P : ~MOD_P;

  always_comb begin
    slice_a = a_q[cnt_q*CHUNK_W +: CHUNK_W];
    slice_b = b_q[cnt_q*CHUNK_W +: CHUNK_W];
    if (state_q == StReduce) begin
      slice_a = res_q[cnt_q*CHUNK_W +: CHUNK_W];
      slice_b = mod_op[cnt_q*CHUNK_W +: CHUNK_W];
    end
  end

  cla_chunk_add #(
    .W (CHUNK_W)
  ) u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    res_d   = res_q;
    cout_d  = cout_q;
`ifdef CHUNKED_ADD_MOD_SUB_EN
    c1_d    = c1_q;
    red     = a_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = sub_in ? ~b_in : b_in;
          sub_d   = sub_in;
          carry_d = sub_in;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        res_d[cnt_q*CHUNK_W +: CHUNK_W] = slice_sum;
        carry_d = slice_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
`ifdef CHUNKED_ADD_MOD_SUB_EN
          c1_d    = slice_cout;
          carry_d = ~sub_q;
          cout_d  = 1'b0;
          state_d = StReduce;
`else
          cout_d  = slice_cout;
          state_d = StDone;
`endif
        end
      end
`ifdef CHUNKED_ADD_MOD_SUB_EN
      StReduce: begin
        // a_q is free after the first pass and holds the reduced candidate.
        a_d[cnt_q*CHUNK_W +: CHUNK_W] = slice_sum;
        carry_d = slice_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = StDone;
          red[cnt_q*CHUNK_W +: CHUNK_W] = slice_sum;
          if (sub_q ? ~c1_q : (c1_q | slice_cout)) res_d = red;
        end
      end
`endif
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
    end
  end

`ifdef CHUNKED_ADD_MOD_SUB_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) c1_q <= 1'b0;
    else     c1_q <= c1_d;
  end
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum_out   = res_q;
  assign carry_out = cout_q;

endmodule
